// File: rtl/sliced_adder_pkg.sv
// Shared types and constants for the sliced adder/subtractor.
//   sa_state_t : control FSM states
//   SA_ADD/SA_SUB : values of the 'sub' mode input
package sliced_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam logic SA_ADD = 1'b0;
  localparam logic SA_SUB = 1'b1;

endpackage : sliced_adder_pkg

// File: rtl/sliced_adder_if.sv
// Operand/result handshake bundle for sliced_adder.
//   source side : in_valid, a, b, sub  -> adder ; in_ready <- adder
//   result side : out_valid, sum, cout, ovf -> consumer ; out_ready <- consumer
// modport slave is the adder's view, master is the environment's view.
interface sliced_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

endinterface : sliced_adder_if

// File: rtl/sliced_adder_slice_add.sv
// Combinational SLICE-bit adder used once per RUN cycle.
//   x, y     : slice operands
//   cin      : carry into the slice
//   s        : slice sum
//   co       : carry out of the slice
//   c_msb_in : carry into the slice's top bit (feeds signed overflow)
module slice_add #(
  parameter int unsigned SLICE = 2
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [SLICE:0] w_full;

  assign w_full   = {1'b0, x} + {1'b0, y} + (SLICE+1)'(cin);
  assign s        = w_full[SLICE-1:0];
  assign co       = w_full[SLICE];
  // Top sum bit is x^y^carry_in, so the carry into it can be recovered.
  assign c_msb_in = x[SLICE-1] ^ y[SLICE-1] ^ w_full[SLICE-1];

endmodule : slice_add

// File: rtl/sliced_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands SLICE bits per clock.
//   clk   : rising-edge clock
//   Reset : asynchronous active-high reset
//   bus   : sliced_adder_if.slave (operand and result handshakes)
// Subtraction is a + ~b + 1, with the +1 seeded into the carry flop.
module sliced_adder
  import sliced_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input logic           clk,
  input logic           Reset,
  sliced_adder_if.slave bus
);

  localparam int unsigned NSLICE = (SLICE == 0) ? 1 : WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Reject illegal parameterisations at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("sliced_adder: WIDTH must be >= 1");
  end
  if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("sliced_adder: SLICE must be 1..WIDTH and divide WIDTH");
  end

  sa_state_t        r_state;
  sa_state_t        w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic             r_carry;
  logic [KW-1:0]    r_k;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [SLICE-1:0] w_x;
  logic [SLICE-1:0] w_y;
  logic [SLICE-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;

  // Slice k of each operand register.
  assign w_x = SLICE'(r_a >> (r_k * SLICE));
  assign w_y = SLICE'(r_b >> (r_k * SLICE));

  slice_add #(.SLICE(SLICE)) u_slice (
    .x        (w_x),
    .y        (w_y),
    .cin      (r_carry),
    .s        (w_s),
    .co       (w_co),
    .c_msb_in (w_cmsb)
  );

  // Working result with slice k replaced by this cycle's slice sum.
  always_comb begin
    w_work_nxt = r_work;
    for (int i = 0; i < int'(NSLICE); i++) begin
      if (KW'(i) == r_k) w_work_nxt[i*SLICE +: SLICE] = w_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_k == KW'(NSLICE - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs (decoded from next state).
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_work      <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= (bus.sub == SA_SUB) ? ~bus.b : bus.b;
        r_carry <= bus.sub;
        r_k     <= '0;
      end else if (r_state == RUN) begin
        r_work  <= w_work_nxt;
        r_carry <= w_co;
        r_k     <= r_k + KW'(1);
        if (w_last) begin
          r_sum  <= w_work_nxt;
          r_cout <= w_co;
          r_ovf  <= w_cmsb ^ w_co;
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule : sliced_adder

// File: tb/tb_sliced_adder.sv
// Self-checking bench for sliced_adder: three instances (3/3, 8/2, 8/1)
// driven by one directed sequence, with a result scoreboard queue.
module tb_sliced_adder;
  import sliced_adder_pkg::*;

  bit          clk = 1'b0;
  logic        Reset;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sliced_adder_if #(.WIDTH(3)) if3 ();
  sliced_adder_if #(.WIDTH(8)) if2 ();
  sliced_adder_if #(.WIDTH(8)) if1 ();

  sliced_adder #(.WIDTH(3), .SLICE(3)) u3 (.clk(clk), .Reset(Reset), .bus(if3.slave));
  sliced_adder #(.WIDTH(8), .SLICE(2)) u2 (.clk(clk), .Reset(Reset), .bus(if2.slave));
  sliced_adder #(.WIDTH(8), .SLICE(1)) u1 (.clk(clk), .Reset(Reset), .bus(if1.slave));

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic s);
    case (id)
      3:       begin if3.in_valid = v; if3.a = 3'(a); if3.b = 3'(b); if3.sub = s; end
      2:       begin if2.in_valid = v; if2.a = a; if2.b = b; if2.sub = s; end
      default: begin if1.in_valid = v; if1.a = a; if1.b = b; if1.sub = s; end
    endcase
  endtask

  task automatic set_ordy(input int id, input logic v);
    case (id)
      3:       if3.out_ready = v;
      2:       if2.out_ready = v;
      default: if1.out_ready = v;
    endcase
  endtask

  task automatic sample(input int id, output logic rdy, output logic ov,
                        output logic [7:0] sm, output logic co, output logic of);
    case (id)
      3:       begin rdy = if3.in_ready; ov = if3.out_valid; sm = 8'(if3.sum);
                     co = if3.cout; of = if3.ovf; end
      2:       begin rdy = if2.in_ready; ov = if2.out_valid; sm = if2.sum;
                     co = if2.cout; of = if2.ovf; end
      default: begin rdy = if1.in_ready; ov = if1.out_valid; sm = if1.sum;
                     co = if1.cout; of = if1.ovf; end
    endcase
  endtask

  // Compare the current outputs of instance id against the oldest expectation.
  task automatic pop_cmp(input string tag, input int id);
    logic rdy, ov, co, of;
    logic [7:0] sm;
    exp_t e;
    sample(id, rdy, ov, sm, co, of);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"},  32'(sm), 32'(e.sum));
      chk({tag, "_cout"}, 32'(co), 32'(e.cout));
      chk({tag, "_ovf"},  32'(of), 32'(e.ovf));
    end
  endtask

  // 8-bit reference: two's-complement add/subtract with flags.
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bb;
    logic [8:0] full;
    exp_t e;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + 9'(s);
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    return e;
  endfunction

  // One transaction: accept, check latency/result, optional backpressure hold, release.
  task automatic op(input int id, input logic [7:0] a, input logic [7:0] b, input logic s,
                    input exp_t e, input int lat, input int hold);
    logic rdy, ov, co, of, co0, of0;
    logic [7:0] sm, sm0;
    int n;
    sample(id, rdy, ov, sm, co, of);
    n = 0;
    while (!rdy && n < 20) begin
      @(posedge clk); #1;
      sample(id, rdy, ov, sm, co, of);
      n++;
    end
    chk("ready_wait", 32'(rdy), 1);
    drive(id, 1'b1, a, b, s);
    @(posedge clk); #1;
    if (hold == 0) drive(id, 1'b0, a, b, s);
    sb.push_back(e);
    n = 0;
    sample(id, rdy, ov, sm, co, of);
    while (!ov && n < 20) begin
      @(posedge clk); #1;
      n++;
      sample(id, rdy, ov, sm, co, of);
    end
    chk("latency", 32'(n), 32'(lat));
    pop_cmp("result", id);
    sample(id, rdy, ov, sm0, co0, of0);
    for (int h = 0; h < hold; h++) begin
      drive(id, 1'b1, ~a, ~b, ~s);
      @(posedge clk); #1;
      sample(id, rdy, ov, sm, co, of);
      chk("bp_valid", 32'(ov), 1);
      chk("bp_hold", 32'({sm, co, of}), 32'({sm0, co0, of0}));
      chk("bp_ready", 32'(rdy), 0);
    end
    drive(id, 1'b0, a, b, s);
    set_ordy(id, 1'b1);
    @(posedge clk); #1;
    set_ordy(id, 1'b0);
    sample(id, rdy, ov, sm, co, of);
    chk("idle_ready", 32'(rdy), 1);
    chk("idle_valid", 32'(ov), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy, ov, co, of, acc, got, seen;
    logic [7:0] sm, ua, ub;
    logic us;
    int t;
    int unsigned last_acc;

    Reset = 1'b1;
    for (int id = 1; id <= 3; id++) begin
      drive(id, 1'b0, 8'h00, 8'h00, SA_ADD);
      set_ordy(id, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    sample(2, rdy, ov, sm, co, of);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_outs", 32'({sm, co, of}), 0);
    Reset = 1'b0;
    @(posedge clk); #1;
    sample(2, rdy, ov, sm, co, of);
    chk("post_rst_ready", 32'(rdy), 1);

    // Single-slice 3-bit case with a short hold.
    op(3, 8'h04, 8'h05, SA_ADD, {8'h01, 1'b1, 1'b1}, 1, 3);

    // 8-bit, 2-bit slices.
    op(2, 8'h64, 8'h65, SA_ADD, {8'hC9, 1'b0, 1'b1}, 4, 0);
    op(2, 8'hFF, 8'h01, SA_ADD, {8'h00, 1'b1, 1'b0}, 4, 0);
    op(2, 8'h05, 8'h07, SA_SUB, {8'hFE, 1'b0, 1'b0}, 4, 0);
    op(2, 8'h80, 8'h01, SA_SUB, {8'h7F, 1'b1, 1'b1}, 4, 10);

    // Reset after two slices of a RUN.
    drive(2, 1'b1, 8'h11, 8'h22, SA_ADD);
    @(posedge clk); #1;
    drive(2, 1'b0, 8'h11, 8'h22, SA_ADD);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    #2;
    sample(2, rdy, ov, sm, co, of);
    chk("midrst_outs", 32'({sm, co, of}), 0);
    chk("midrst_valid", 32'(ov), 0);
    chk("midrst_ready", 32'(rdy), 0);
    Reset = 1'b0;
    seen = 1'b0;
    set_ordy(2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sample(2, rdy, ov, sm, co, of);
      if (ov) seen = 1'b1;
    end
    set_ordy(2, 1'b0);
    chk("midrst_no_valid", 32'(seen), 0);
    op(2, 8'h10, 8'h20, SA_ADD, {8'h30, 1'b0, 1'b0}, 4, 0);

    // 8-bit, 1-bit slices: back-to-back random operands, consumer always ready.
    set_ordy(1, 1'b1);
    last_acc = 0;
    for (int i = 0; i < 12; i++) begin
      ua = 8'($urandom);
      ub = 8'($urandom);
      us = 1'($urandom);
      drive(1, 1'b1, ua, ub, us);
      got = 1'b0;
      t = 0;
      while (!got && t < 30) begin
        sample(1, acc, ov, sm, co, of);
        @(posedge clk); #1;
        sample(1, rdy, ov, sm, co, of);
        if (ov) pop_cmp("rand", 1);
        if (acc) got = 1'b1;
        t++;
      end
      chk("rand_accept", 32'(got), 1);
      sb.push_back(model8(ua, ub, us));
      if (i > 0) chk("rand_interval", cyc - last_acc, 10);
      last_acc = cyc;
    end
    drive(1, 1'b0, 8'h00, 8'h00, SA_ADD);
    t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(posedge clk); #1;
      sample(1, rdy, ov, sm, co, of);
      if (ov) pop_cmp("rand", 1);
      t++;
    end
    chk("rand_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sliced_adder
